// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - valid/ready command sequencer for the ALU register-file write port (optional ALU_SEQ_SKIP_EN)
module alu_cmd_sequencer #(
    parameter int OPERAND_WIDTH    = 8,
    parameter int INST_ADDR_LENGTH = 2,
    parameter int ADDR_OP          = 0,
    parameter int ADDR_A           = 1,
    parameter int ADDR_B           = 2,
    parameter int OP_MULT          = 2
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [OPERAND_WIDTH-1:0]    cmd_op,
    input  logic [OPERAND_WIDTH-1:0]    cmd_a,
    input  logic [OPERAND_WIDTH-1:0]    cmd_b,
    output logic                        writeEn,
    output logic [INST_ADDR_LENGTH-1:0] writeAddress,
    output logic [OPERAND_WIDTH-1:0]    inst,
    input  logic [OPERAND_WIDTH-1:0]    alu_result,
    input  logic                        alu_error,
    input  logic                        alu_zero,
    input  logic                        alu_carry,
    input  logic                        alu_overflow,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [OPERAND_WIDTH-1:0]    rsp_result,
    output logic                        rsp_error,
    output logic                        rsp_zero,
    output logic                        rsp_carry,
    output logic                        rsp_overflow,
    output logic                        busy
);
    localparam int OW = OPERAND_WIDTH;
    localparam int AW = INST_ADDR_LENGTH;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR_A      = 3'd1;
    localparam logic [2:0] S_WR_B      = 3'd2;
    localparam logic [2:0] S_WR_OP     = 3'd3;
    localparam logic [2:0] S_SETTLE    = 3'd4;
    localparam logic [2:0] S_MULT_WAIT = 3'd5;
    localparam logic [2:0] S_RESP      = 3'd6;

    localparam logic [OW-1:0] MULT_CODE = OW'(OP_MULT);
    localparam logic [AW-1:0] OP_ADDR   = AW'(ADDR_OP);
    localparam logic [AW-1:0] A_ADDR    = AW'(ADDR_A);
    localparam logic [AW-1:0] B_ADDR    = AW'(ADDR_B);

    logic [2:0]    state, state_d;
    logic [OW-1:0] op_q, a_q, b_q;
    logic [2:0]    need_q;      // {op, b, a}: which registers this command writes
    logic [2:0]    need_new;
    logic          hold_q, hold_d;
    logic          capture;
    logic          we_d;
    logic [AW-1:0] addr_d;
    logic [OW-1:0] inst_d;
    logic [OW-1:0] a_src, b_src, op_src;

    // Earliest pending write, in operand-first order, or SETTLE if none remain.
    function automatic logic [2:0] first_write(input logic [2:0] need);
        if (need[0])      return S_WR_A;
        else if (need[1]) return S_WR_B;
        else if (need[2]) return S_WR_OP;
        else              return S_SETTLE;
    endfunction

`ifdef ALU_SEQ_SKIP_EN
    logic [OW-1:0] sh_a, sh_b, sh_op;
    logic [2:0]    sh_vld;

    assign need_new = {!(sh_vld[2] && (sh_op == cmd_op)),
                       !(sh_vld[1] && (sh_b  == cmd_b)),
                       !(sh_vld[0] && (sh_a  == cmd_a))};

    // Shadow of each ALU register, refreshed only when a write is actually issued.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sh_a   <= '0;
            sh_b   <= '0;
            sh_op  <= '0;
            sh_vld <= 3'b000;
        end else begin
            if (state_d == S_WR_A) begin
                sh_a      <= a_src;
                sh_vld[0] <= 1'b1;
            end
            if (state_d == S_WR_B) begin
                sh_b      <= b_src;
                sh_vld[1] <= 1'b1;
            end
            if (state_d == S_WR_OP) begin
                sh_op     <= op_src;
                sh_vld[2] <= 1'b1;
            end
        end
    end
`else
    assign need_new = 3'b111;
`endif

    // In IDLE the command is not latched yet, so writes source straight from the port.
    assign a_src  = (state == S_IDLE) ? cmd_a  : a_q;
    assign b_src  = (state == S_IDLE) ? cmd_b  : b_q;
    assign op_src = (state == S_IDLE) ? cmd_op : op_q;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);

    // Next-state selection; an all-skipped command spends one extra cycle in SETTLE
    // so the fastest response still arrives two cycles after acceptance.
    always_comb begin
        state_d = state;
        hold_d  = hold_q;
        capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = first_write(need_new);
                    hold_d  = (need_new == 3'b000);
                end
            end
            S_WR_A:  state_d = first_write(need_q & 3'b110);
            S_WR_B:  state_d = first_write(need_q & 3'b100);
            S_WR_OP: state_d = S_SETTLE;
            S_SETTLE: begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else if (op_q == MULT_CODE) begin
                    state_d = S_MULT_WAIT;
                end else begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_MULT_WAIT: begin
                capture = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write-port values for the state being entered, so they are registered outputs.
    always_comb begin
        we_d   = 1'b0;
        addr_d = writeAddress;
        inst_d = inst;
        case (state_d)
            S_WR_A: begin
                we_d   = 1'b1;
                addr_d = A_ADDR;
                inst_d = a_src;
            end
            S_WR_B: begin
                we_d   = 1'b1;
                addr_d = B_ADDR;
                inst_d = b_src;
            end
            S_WR_OP: begin
                we_d   = 1'b1;
                addr_d = OP_ADDR;
                inst_d = op_src;
            end
            default: ;
        endcase
    end

    // State, write port, latched command and captured response registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state        <= S_IDLE;
            hold_q       <= 1'b0;
            writeEn      <= 1'b0;
            writeAddress <= '0;
            inst         <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            need_q       <= 3'b000;
            rsp_result   <= '0;
            rsp_error    <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            state        <= state_d;
            hold_q       <= hold_d;
            writeEn      <= we_d;
            writeAddress <= addr_d;
            inst         <= inst_d;
            if ((state == S_IDLE) && cmd_valid) begin
                op_q   <= cmd_op;
                a_q    <= cmd_a;
                b_q    <= cmd_b;
                need_q <= need_new;
            end
            if (capture) begin
                rsp_result   <= alu_result;
                rsp_error    <= alu_error;
                rsp_zero     <= alu_zero;
                rsp_carry    <= alu_carry;
                rsp_overflow <= alu_overflow;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer with a small ALU model
module tb_alu_cmd_sequencer;
    localparam logic [7:0] OP_ADD    = 8'd0;
    localparam logic [7:0] OP_SUB    = 8'd1;
    localparam logic [7:0] OP_MULT   = 8'd2;
    localparam logic [7:0] OP_DIVIDE = 8'd3;
    localparam logic [7:0] OP_MFHI   = 8'd4;
    localparam logic [7:0] OP_MFLO   = 8'd5;
    localparam logic [7:0] OP_BAD    = 8'h0F;

    logic       clk = 1'b0;
    logic       rstN;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_op, cmd_a, cmd_b;
    logic       writeEn;
    logic [1:0] writeAddress;
    logic [7:0] inst;
    logic [7:0] alu_result;
    logic       alu_error, alu_zero, alu_carry, alu_overflow;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_error, rsp_zero, rsp_carry, rsp_overflow;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .OPERAND_WIDTH(8), .INST_ADDR_LENGTH(2),
        .ADDR_OP(0), .ADDR_A(1), .ADDR_B(2), .OP_MULT(2)
    ) dut (
        .clk(clk), .rstN(rstN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .writeEn(writeEn), .writeAddress(writeAddress), .inst(inst),
        .alu_result(alu_result), .alu_error(alu_error), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error), .rsp_zero(rsp_zero),
        .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
        .busy(busy)
    );

    // ALU model: register file, hi/lo updated on the edge after a MULT opcode lands.
    logic [7:0] r_op, r_a, r_b, hi, lo;
    logic       op_wr;
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_op <= 8'd0; r_a <= 8'd0; r_b <= 8'd0; hi <= 8'd0; lo <= 8'd0; op_wr <= 1'b0;
        end else begin
            if (writeEn) begin
                case (writeAddress)
                    2'd0: r_op <= inst;
                    2'd1: r_a  <= inst;
                    2'd2: r_b  <= inst;
                    default: ;
                endcase
            end
            op_wr <= writeEn && (writeAddress == 2'd0);
            if (op_wr && (r_op == OP_MULT)) {hi, lo} <= r_a * r_b;
        end
    end

    logic [8:0] wide;
    always_comb begin
        wide = 9'd0; alu_result = 8'd0; alu_error = 1'b0; alu_carry = 1'b0; alu_overflow = 1'b0;
        case (r_op)
            OP_ADD: begin
                wide = {1'b0, r_a} + {1'b0, r_b};
                alu_result = wide[7:0]; alu_carry = wide[8];
                alu_overflow = (r_a[7] == r_b[7]) && (wide[7] != r_a[7]);
            end
            OP_SUB: begin
                wide = {1'b0, r_a} - {1'b0, r_b};
                alu_result = wide[7:0]; alu_carry = wide[8];
                alu_overflow = (r_a[7] != r_b[7]) && (wide[7] != r_a[7]);
            end
            OP_MULT: alu_result = lo;
            OP_MFHI: alu_result = hi;
            OP_MFLO: alu_result = lo;
            OP_DIVIDE: begin
                if (r_b == 8'd0) alu_error = 1'b1;
                else alu_result = r_a / r_b;
            end
            default: alu_error = 1'b1;
        endcase
        alu_zero = (alu_result == 8'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // hold > 0: keep rsp_ready low that many cycles; hold < 0: rsp_ready high before rsp_valid.
    task automatic run_cmd(input string tag, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int exp_lat, input int exp_nwr, input logic [7:0] exp_seq,
                           input logic [7:0] exp_res, input logic exp_err, input logic exp_zero,
                           input logic exp_carry, input logic exp_ovf, input int hold);
        int cyc;
        int nwr;
        logic [7:0] seq;
        logic [7:0] want_inst;
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        if (hold < 0) rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0; cmd_op = ~op; cmd_a = ~a; cmd_b = ~b;
        check({tag, "_busy"}, busy, 1);
        cyc = 0; nwr = 0; seq = 8'd0;
        while (!rsp_valid && cyc < 20) begin
            if (writeEn) begin
                nwr++;
                seq = {seq[5:0], writeAddress};
                want_inst = (writeAddress == 2'd0) ? op : (writeAddress == 2'd1) ? a : b;
                check({tag, "_inst"}, inst, want_inst);
            end
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_nwrites"}, nwr, exp_nwr);
        check({tag, "_wr_order"}, seq, exp_seq);
        check({tag, "_result"}, rsp_result, exp_res);
        check({tag, "_flags"}, {rsp_error, rsp_zero, rsp_carry, rsp_overflow},
              {exp_err, exp_zero, exp_carry, exp_ovf});
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_result"}, rsp_result, exp_res);
            check({tag, "_hold_valid"}, rsp_valid, 1);
            check({tag, "_hold_busy"}, {cmd_ready, busy}, 2'b01);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_done"}, {rsp_valid, cmd_ready, busy}, 3'b010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstN = 1'b0; cmd_valid = 1'b0; cmd_op = 8'd0; cmd_a = 8'd0; cmd_b = 8'd0; rsp_ready = 1'b0;
        repeat (3) tick();
        check("reset_write_port", {writeEn, writeAddress, inst}, 11'd0);
        check("reset_rsp", {rsp_valid, rsp_result, rsp_error, rsp_zero, rsp_carry, rsp_overflow}, 13'd0);
        check("reset_ready_busy", {cmd_ready, busy}, 2'b10);
        rstN = 1'b1;
        tick();

        run_cmd("add",    OP_ADD,    8'd200, 8'd100, 4, 3, 8'h18, 8'd44,  0, 0, 1, 0, 0);
        run_cmd("div0",   OP_DIVIDE, 8'd50,  8'd0,   4, 3, 8'h18, 8'd0,   1, 1, 0, 0, 0);
        run_cmd("mult",   OP_MULT,   8'd20,  8'd30,  5, 3, 8'h18, 8'h58,  0, 0, 0, 0, 0);
        run_cmd("mfhi",   OP_MFHI,   8'd0,   8'd0,   4, 3, 8'h18, 8'h02,  0, 0, 0, 0, 0);
        run_cmd("mflo",   OP_MFLO,   8'd1,   8'd1,   4, 3, 8'h18, 8'h58,  0, 0, 0, 0, -1);
        run_cmd("badop",  OP_BAD,    8'd1,   8'd2,   4, 3, 8'h18, 8'd0,   1, 1, 0, 0, 0);
        run_cmd("bp",     OP_ADD,    8'd200, 8'd100, 4, 3, 8'h18, 8'd44,  0, 0, 1, 0, 6);

        // Abort during WR_B.
        cmd_op = OP_ADD; cmd_a = 8'd9; cmd_b = 8'd9; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("abort_in_wr_b", {writeEn, writeAddress}, 3'b110);
        #2 rstN = 1'b0;
        #1;
        check("abort_write_port", {writeEn, inst}, 9'd0);
        check("abort_rsp_busy", {rsp_valid, busy, cmd_ready}, 3'b001);
        tick();
        rstN = 1'b1;
        tick();
        check("abort_idle", {rsp_valid, busy, cmd_ready}, 3'b001);

        run_cmd("add34",  OP_ADD,    8'd3,   8'd4,   4, 3, 8'h18, 8'd7,   0, 0, 0, 0, 0);
`ifdef ALU_SEQ_SKIP_EN
        run_cmd("add34b", OP_ADD,    8'd3,   8'd4,   2, 0, 8'h00, 8'd7,   0, 0, 0, 0, 0);
        run_cmd("sub34",  OP_SUB,    8'd3,   8'd4,   2, 1, 8'h00, 8'hFF,  0, 0, 1, 0, 0);
`else
        run_cmd("add34b", OP_ADD,    8'd3,   8'd4,   4, 3, 8'h18, 8'd7,   0, 0, 0, 0, 0);
        run_cmd("sub34",  OP_SUB,    8'd3,   8'd4,   4, 3, 8'h18, 8'hFF,  0, 0, 1, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator for the ALU's register-file write port. It accepts one operation (opcode, A, B) on a valid/ready command interface and drives the writeEn/writeAddress/inst sequence into the ALU. It then waits the required settle/multiply cycles, captures result and flags into registers, and returns them on a valid/ready response interface. It sits between any command source (test controller, UART bridge, CPU stub) and the ALU.

Parameters:
OPERAND_WIDTH, 8, width of operands, opcode word, inst and result; must match the ALU.
INST_ADDR_LENGTH, 2, width of writeAddress; must match the ALU.
ADDR_OP, 0, ALU register index holding the opcode.
ADDR_A, 1, ALU register index holding operand A.
ADDR_B, 2, ALU register index holding operand B.

Ports:
clk  in  1  system clock, rising edge.
rstN  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command.
cmd_op  in  OPERAND_WIDTH  opcode, encoded with the shared ALU constants header (OP_ADD, OP_MULT, OP_MFHI, ...).
cmd_a  in  OPERAND_WIDTH  operand A.
cmd_b  in  OPERAND_WIDTH  operand B.
writeEn  out  1  to ALU register-file write enable.
writeAddress  out  INST_ADDR_LENGTH  to ALU register index.
inst  out  OPERAND_WIDTH  to ALU write data.
alu_result, alu_error, alu_zero, alu_carry, alu_overflow  in  OPERAND_WIDTH,1,1,1,1  from ALU outputs.
rsp_valid  out  1  response registers hold a captured result.
rsp_ready  in  1  consumer accepts the response.
rsp_result  out  OPERAND_WIDTH  captured result.
rsp_error, rsp_zero, rsp_carry, rsp_overflow  out  1 each  captured flags.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rstN low, asynchronous) forces:
  - state IDLE;
  - writeEn=0, writeAddress=0, inst=0;
  - rsp_valid=0, rsp_result=0, all rsp flags 0;
  - cmd_ready=1, busy=0;
  - latched command registers cleared.
- Reset asserted mid-operation aborts the operation with no response. writeEn drops in the same cycle.
- States: IDLE -> WR_A -> WR_B -> WR_OP -> SETTLE -> [MULT_WAIT] -> RESP -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch cmd_op, cmd_a and cmd_b, then go to WR_A.
- WR_A: writeEn=1, writeAddress=ADDR_A, inst=A.
- WR_B: writeEn=1, writeAddress=ADDR_B, inst=B.
- WR_OP: writeEn=1, writeAddress=ADDR_OP, inst=op.
- Write order rule: the opcode is always written last, so the ALU never evaluates a new opcode with stale operands.
- Exactly one write per cycle. writeEn is 0 in all other states. inst and writeAddress are registered outputs.
- SETTLE:
  - writeEn=0.
  - If op!=OP_MULT, capture alu_* into rsp_* at the closing edge and go to RESP.
  - If op==OP_MULT, go to MULT_WAIT without capturing. The ALU updates hi/lo at this edge.
- MULT_WAIT: capture alu_* (the low product) and go to RESP.
- RESP:
  - rsp_valid=1; rsp_* are held stable.
  - On rsp_ready, rsp_valid falls next cycle and the state returns to IDLE.
  - rsp_ready may be high before rsp_valid; that is legal and gives zero-wait acceptance.
- Latency from the accept edge to rsp_valid high: 4 cycles for non-MULT, 5 cycles for MULT.
- cmd_ready=0 from the accept edge until back in IDLE.
- cmd_* changes while busy are ignored.
- OP_MFLO/OP_MFHI follow the normal path with their A/B writes. hi/lo are not disturbed because the opcode is not OP_MULT.
- Invalid opcode: forwarded unchanged; the ALU's error flag is captured as-is.

Optional Feature:
ALU_SEQ_SKIP_EN.
- Defined:
  - Shadow copies of the last value written to each ALU register are kept, each with a valid bit cleared on reset.
  - WR_A, WR_B and WR_OP are each skipped when their shadow is valid and equals the new value. Skipped states go directly to the next needed state.
  - If all three match, the path is IDLE -> SETTLE (non-MULT rsp_valid 2 cycles after accept; MULT 3 cycles).
  - Shadows update only on actual writes.
- Undefined: all three writes always occur, and shadow logic is absent.

Test Plan:
- ADD: cmd op=OP_ADD, a=200, b=100 -> writes to addr 1, 2, 0 in consecutive cycles. rsp_valid 4 cycles after accept with rsp_result=44, rsp_carry=1, rsp_error=0, rsp_zero=0.
- Divide by zero: op=OP_DIVIDE, a=50, b=0 -> rsp_result=0, rsp_error=1, rsp_zero=1.
- MULT then MFHI: op=OP_MULT, a=20, b=30 -> rsp_result=0x58 at 5 cycles. Next cmd op=OP_MFHI -> rsp_result=0x02.
- Backpressure: hold rsp_ready=0 for 6 cycles after rsp_valid -> rsp_* stable, cmd_ready=0, busy=1. Raise rsp_ready -> IDLE next cycle, cmd_ready=1.
- Reset mid-operation: deassert rstN during WR_B -> writeEn=0 immediately, rsp_valid=0, state IDLE after release. A following ADD 3+4 -> rsp_result=7.
- ALU_SEQ_SKIP_EN: issue ADD 3+4 twice -> second command has no writeEn pulses and rsp_valid 2 cycles after accept, rsp_result=7. Then SUB 3-4 -> only the addr-0 write occurs, rsp_result=0xFF.
